// File: rtl/gcd_pkg.sv
// ---------------------------------------------------------------------------
// gcd_pkg
// Shared definitions for the GCD operand feeder slice.
//   GCD_WIDTH_DEFAULT : default operand width in bits
//   GCD_DEPTH_DEFAULT : default number of queued operand pairs
//   gcd_state_e       : issue FSM states (S_IDLE / S_ISSUE / S_WAIT)
// No ports (package).
// ---------------------------------------------------------------------------
package gcd_pkg;

    localparam int GCD_WIDTH_DEFAULT = 16;
    localparam int GCD_DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } gcd_state_e;

endpackage : gcd_pkg

// File: rtl/gcd_pair_fifo.sv
// ---------------------------------------------------------------------------
// gcd_pair_fifo
// Small synchronous FIFO holding concatenated operand pairs.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   push         : write push_data this cycle (ignored when full)
//   push_data    : DATA_W-bit entry to store
//   pop          : drop the head entry this cycle (ignored when empty)
//   pop_data     : current head entry (valid while empty is low)
//   count        : number of stored entries, 0..DEPTH
//   full, empty  : derived from count
// Handshake: an entry is written on an edge where push is high and full is
// low; the head is removed on an edge where pop is high and empty is low.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// ---------------------------------------------------------------------------
module gcd_pair_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            // Simultaneous push and pop leave the count unchanged.
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule : gcd_pair_fifo

// File: rtl/gcd_operand_feeder.sv
// ---------------------------------------------------------------------------
// gcd_operand_feeder
// Queues operand pairs and hands them one at a time to a GCD engine that
// signals completion through its idle output.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   in_valid / in_ready   : upstream pair handshake (push when both high)
//   in_a, in_b            : upstream operand pair
//   gcd_idle              : engine idle (input)
//   gcd_input_available   : one-cycle start strobe to the engine
//   gcd_operand_a/_b      : operands presented to the engine, held until the
//                           next pop
//   fifo_count            : pairs currently queued
//   busy                  : FSM not idle, or pairs queued
//   fsm_state             : current issue FSM state (debug observation)
//   issued_count          : 16-bit wrapping issue counter, present only when
//                           GCD_FEED_STATS_EN is defined
// Handshake: a pair is accepted on a rising edge where in_valid and in_ready
// are both high; in_ready depends only on registered FIFO occupancy.
// ---------------------------------------------------------------------------
module gcd_operand_feeder
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH_DEFAULT,
    parameter int DEPTH = GCD_DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    input  logic                   gcd_idle,
    output logic                   gcd_input_available,
    output logic [WIDTH-1:0]       gcd_operand_a,
    output logic [WIDTH-1:0]       gcd_operand_b,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   busy,
    output logic [1:0]             fsm_state
`ifdef GCD_FEED_STATS_EN
    ,
    output logic [15:0]            issued_count
`endif
);

    gcd_state_e        state_q;
    logic              wait_first_q;   // first S_WAIT cycle, gcd_idle ignored
    logic              seen_low_q;     // gcd_idle observed low during S_WAIT
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop_req;
    logic [2*WIDTH-1:0] head_pair;

    gcd_pair_fifo #(
        .DATA_W (2 * WIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_valid),
        .push_data ({in_a, in_b}),
        .pop       (pop_req),
        .pop_data  (head_pair),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // The FIFO ignores push while full, so in_valid alone is safe as push.
    assign in_ready            = !fifo_full;
    assign pop_req             = (state_q == S_IDLE) && !fifo_empty && gcd_idle;
    assign gcd_input_available = (state_q == S_ISSUE);
    assign busy                = (state_q != S_IDLE) || !fifo_empty;
    assign fsm_state           = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            wait_first_q  <= 1'b0;
            seen_low_q    <= 1'b0;
            gcd_operand_a <= '0;
            gcd_operand_b <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop_req) begin
                        gcd_operand_a <= head_pair[2*WIDTH-1:WIDTH];
                        gcd_operand_b <= head_pair[WIDTH-1:0];
                        state_q       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state_q      <= S_WAIT;
                    wait_first_q <= 1'b1;
                    seen_low_q   <= 1'b0;
                end
                S_WAIT: begin
                    // The engine may still report idle right after the start
                    // strobe, so the first cycle is skipped; completion is a
                    // low-then-high transition of gcd_idle after that.
                    if (wait_first_q) begin
                        wait_first_q <= 1'b0;
                    end else if (!seen_low_q) begin
                        if (!gcd_idle) begin
                            seen_low_q <= 1'b1;
                        end
                    end else if (gcd_idle) begin
                        seen_low_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef GCD_FEED_STATS_EN
    logic [15:0] issued_q;

    // Counts S_IDLE-to-S_ISSUE transitions; wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            issued_q <= '0;
        end else if (pop_req) begin
            issued_q <= issued_q + 16'd1;
        end
    end

    assign issued_count = issued_q;
`endif

endmodule : gcd_operand_feeder

// File: tb/tb_gcd_operand_feeder.sv
// ---------------------------------------------------------------------------
// tb_gcd_operand_feeder
// Directed bench for gcd_operand_feeder (WIDTH=16, DEPTH=4). The GCD engine
// is emulated by driving gcd_idle by hand. Inputs change 1 time unit after a
// rising edge; outputs are checked at the same point.
// Build with GCD_FEED_STATS_EN defined to also exercise issued_count.
// ---------------------------------------------------------------------------
module tb_gcd_operand_feeder;

    localparam int W = 16;
    localparam int D = 4;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          gcd_idle;
    logic          gcd_input_available;
    logic [W-1:0]  gcd_operand_a;
    logic [W-1:0]  gcd_operand_b;
    logic [2:0]    fifo_count;
    logic          busy;
    logic [1:0]    fsm_state;
`ifdef GCD_FEED_STATS_EN
    logic [15:0]   issued_count;
`endif

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;
    int p0;

    logic [2*W-1:0] exp_q [$];

    gcd_operand_feeder #(.WIDTH(W), .DEPTH(D)) dut (
        .clk                 (clk),
        .reset               (reset),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_a                (in_a),
        .in_b                (in_b),
        .gcd_idle            (gcd_idle),
        .gcd_input_available (gcd_input_available),
        .gcd_operand_a       (gcd_operand_a),
        .gcd_operand_b       (gcd_operand_b),
        .fifo_count          (fifo_count),
        .busy                (busy),
        .fsm_state           (fsm_state)
`ifdef GCD_FEED_STATS_EN
        ,
        .issued_count        (issued_count)
`endif
    );

    // Clock and reset-free free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count cycles with the start strobe high.
    always @(posedge clk) begin
        if (gcd_input_available === 1'b1) pulses <= pulses + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        if (in_ready) exp_q.push_back({a, b});
        tick();
        in_valid = 1'b0;
    endtask

    // Release the engine, wait for the strobe, check the operands, then emulate
    // one engine run (idle low, then high again).
    task automatic issue_and_complete(input string tag, input logic [W-1:0] ea, input logic [W-1:0] eb);
        logic           found;
        logic [2*W-1:0] sb;
        gcd_idle = 1'b1;
        found    = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            tick();
            if (gcd_input_available) found = 1'b1;
        end
        chk({tag, "_strobe"}, gcd_input_available, 1);
        chk({tag, "_op_a"}, gcd_operand_a, ea);
        chk({tag, "_op_b"}, gcd_operand_b, eb);
        chk({tag, "_sb_nonempty"}, exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
            sb = exp_q.pop_front();
            chk({tag, "_sb_order"}, {gcd_operand_a, gcd_operand_b}, sb);
        end
        gcd_idle = 1'b0;
        tick();
        chk({tag, "_one_cycle"}, gcd_input_available, 0);
        tick();
        tick();
        gcd_idle = 1'b1;
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        gcd_idle = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_count", fifo_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_strobe", gcd_input_available, 0);
        chk("rst_op_a", gcd_operand_a, 0);
        chk("rst_op_b", gcd_operand_b, 0);
        chk("rst_state", fsm_state, 0);
        reset = 1'b0;

        // Single pair latency: push at edge k, strobe after edge k+1
        push_pair(16'd15, 16'd27);
        chk("lat_count_k", fifo_count, 1);
        chk("lat_strobe_k", gcd_input_available, 0);
        tick();
        chk("lat_strobe_k1", gcd_input_available, 1);
        chk("lat_op_a", gcd_operand_a, 15);
        chk("lat_op_b", gcd_operand_b, 27);
        chk("lat_state_issue", fsm_state, 1);
        void'(exp_q.pop_front());
        gcd_idle = 1'b0;
        tick();
        chk("lat_strobe_k2", gcd_input_available, 0);
        chk("lat_state_wait", fsm_state, 2);
        tick();
        tick();
        gcd_idle = 1'b1;
        tick();
        chk("lat_back_idle", fsm_state, 0);
        chk("lat_not_busy", busy, 0);
        chk("lat_op_hold_a", gcd_operand_a, 15);

        // Fill with engine busy: fifth pair must be refused
        gcd_idle = 1'b0;
        p0 = pulses;
        push_pair(16'd15, 16'd27);
        push_pair(16'd30, 16'd27);
        push_pair(16'd8, 16'd12);
        push_pair(16'd9, 16'd6);
        chk("full_count", fifo_count, 4);
        chk("full_in_ready", in_ready, 0);
        push_pair(16'd1, 16'd1);
        chk("full_count_after5", fifo_count, 4);
        chk("full_no_issue", gcd_input_available, 0);
        chk("full_state_idle", fsm_state, 0);
        chk("full_sb_size", exp_q.size(), 4);

        // Drain in order, one strobe each
        issue_and_complete("drain0", 16'd15, 16'd27);
        chk("drain0_in_ready", in_ready, 1);
        issue_and_complete("drain1", 16'd30, 16'd27);
        issue_and_complete("drain2", 16'd8, 16'd12);
        issue_and_complete("drain3", 16'd9, 16'd6);
        tick();
        tick();
        tick();
        chk("drain_state_idle", fsm_state, 0);
        chk("drain_count", fifo_count, 0);
        chk("drain_pulses", pulses - p0, 4);

        // Simultaneous push and pop at count 2
        gcd_idle = 1'b0;
        push_pair(16'd2, 16'd4);
        push_pair(16'd6, 16'd8);
        chk("pp_count_before", fifo_count, 2);
        gcd_idle = 1'b1;
        push_pair(16'd10, 16'd12);
        chk("pp_count_after", fifo_count, 2);
        chk("pp_strobe", gcd_input_available, 1);
        chk("pp_op_a", gcd_operand_a, 2);
        chk("pp_op_b", gcd_operand_b, 4);
        void'(exp_q.pop_front());
        gcd_idle = 1'b0;
        tick();
        tick();
        tick();
        issue_and_complete("pp1", 16'd6, 16'd8);
        issue_and_complete("pp2", 16'd10, 16'd12);
        tick();
        tick();
        chk("pp_idle", fsm_state, 0);

        // Reset while waiting on the engine with three pairs queued
        gcd_idle = 1'b0;
        push_pair(16'd11, 16'd1);
        push_pair(16'd12, 16'd2);
        push_pair(16'd13, 16'd3);
        push_pair(16'd14, 16'd4);
        gcd_idle = 1'b1;
        tick();
        gcd_idle = 1'b0;
        tick();
        chk("mid_state_wait", fsm_state, 2);
        chk("mid_count", fifo_count, 3);
        reset = 1'b1;
        tick();
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_state", fsm_state, 0);
        chk("mid_rst_strobe", gcd_input_available, 0);
        chk("mid_rst_op_a", gcd_operand_a, 0);
        chk("mid_rst_op_b", gcd_operand_b, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_busy", busy, 0);
`ifdef GCD_FEED_STATS_EN
        chk("stats_rst", issued_count, 0);
`endif
        reset = 1'b0;
        exp_q.delete();
        p0 = pulses;
        gcd_idle = 1'b1;
        tick();
        tick();
        tick();
        chk("mid_no_replay", pulses - p0, 0);

`ifdef GCD_FEED_STATS_EN
        // Issue counter: three issues, then wrap from 0xFFFF
        gcd_idle = 1'b0;
        push_pair(16'd21, 16'd7);
        push_pair(16'd22, 16'd8);
        push_pair(16'd23, 16'd9);
        issue_and_complete("st0", 16'd21, 16'd7);
        issue_and_complete("st1", 16'd22, 16'd8);
        issue_and_complete("st2", 16'd23, 16'd9);
        tick();
        chk("stats_three", issued_count, 3);
        dut.issued_q = 16'hFFFF;
        gcd_idle = 1'b0;
        push_pair(16'd5, 16'd10);
        issue_and_complete("st3", 16'd5, 16'd10);
        chk("stats_wrap", issued_count, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_gcd_operand_feeder
